// File: rtl/magnet_sequencer_if.sv
// Command/pulse bundle between the move controller and the magnet sequencer.
//   master : move controller side (drives commands, estop, fault_clr)
//   slave  : magnet_sequencer side (drives ready, pulses, status)
// Signals:
//   cmd_valid, cmd_grab, cmd_release : command request (release wins over grab)
//   cmd_ready                        : sequencer can accept a command this cycle
//   estop                            : emergency stop, level-sensitive
//   fault_clr                        : clears the sticky watchdog fault
//   magnet_on, magnet_off            : one-cycle pulses to the magnet hold register
//   done                             : one-cycle pulse, accepted command completed
//   holding                          : commanded magnet state, 1 = on
//   fault                            : sticky watchdog flag
interface magnet_sequencer_if;
  logic cmd_valid;
  logic cmd_grab;
  logic cmd_release;
  logic cmd_ready;
  logic estop;
  logic fault_clr;
  logic magnet_on;
  logic magnet_off;
  logic done;
  logic holding;
  logic fault;

  modport master (
    output cmd_valid,
    output cmd_grab,
    output cmd_release,
    output estop,
    output fault_clr,
    input  cmd_ready,
    input  magnet_on,
    input  magnet_off,
    input  done,
    input  holding,
    input  fault
  );

  modport slave (
    input  cmd_valid,
    input  cmd_grab,
    input  cmd_release,
    input  estop,
    input  fault_clr,
    output cmd_ready,
    output magnet_on,
    output magnet_off,
    output done,
    output holding,
    output fault
  );
endinterface

// File: rtl/magnet_sequencer.sv
// Magnet sequencer: turns grab/release commands into single-cycle magnet_on /
// magnet_off pulses for the magnet hold register, waits a settle time before
// reporting done, and force-releases a magnet held too long (thermal watchdog),
// followed by a command lockout.
// Ports:
//   clk   : system clock
//   rst_n : synchronous reset, active-low (magnet_off held high while low)
//   bus   : magnet_sequencer_if.slave (commands in; pulses, ready, status out)
// All outputs are driven straight from registers.
module magnet_sequencer #(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned SETTLE_CYCLES   = 2_500_000,
  parameter int unsigned MAX_HOLD_CYCLES = 500_000_000,
  parameter int unsigned COOLDOWN_CYCLES = 250_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  magnet_sequencer_if.slave   bus
);

  // Counters sit at 0 in the first cycle of a phase, so the terminal compare
  // is against count-1 and the registered result lands exactly on the count.
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(MAX_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CoolLast   = CNT_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdleOff,
    StSettleOn,
    StHolding,
    StSettleOff,
    StCooldown
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;  // settle / cooldown timer
  logic [CNT_W-1:0] hold_q,  hold_d;   // on-time since the magnet_on pulse
  logic             on_q,      on_d;
  logic             off_q,     off_d;
  logic             done_q,    done_d;
  logic             ready_q,   ready_d;
  logic             holding_q, holding_d;
  logic             fault_q,   fault_d;

  logic accept;
  logic is_release;
  logic is_grab;
  logic hold_active;
  logic wd_fire;

  assign accept      = bus.cmd_valid & ready_q;
  assign is_release  = bus.cmd_release;
  assign is_grab     = bus.cmd_grab & ~bus.cmd_release;
  assign hold_active = (state_q == StSettleOn) || (state_q == StHolding);
  assign wd_fire     = hold_active && (hold_q == HoldLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdleOff;
      phase_q   <= '0;
      hold_q    <= '0;
      on_q      <= 1'b0;
      off_q     <= 1'b1;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      holding_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      hold_q    <= hold_d;
      on_q      <= on_d;
      off_q     <= off_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      holding_q <= holding_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 1'b1;
    hold_d    = hold_q;
    on_d      = 1'b0;
    off_d     = 1'b0;
    done_d    = 1'b0;
    ready_d   = ready_q;
    holding_d = holding_q;
    fault_d   = bus.fault_clr ? 1'b0 : fault_q;

    if (bus.estop) begin
      // Keep commanding off for as long as estop is held, like reset does.
      state_d   = StIdleOff;
      off_d     = 1'b1;
      ready_d   = 1'b0;
      holding_d = 1'b0;
      phase_d   = '0;
      hold_d    = '0;
    end else if (wd_fire) begin
      // Outranks any command accepted on the same edge; that command is dropped.
      state_d   = StCooldown;
      off_d     = 1'b1;
      fault_d   = 1'b1;
      ready_d   = 1'b0;
      holding_d = 1'b0;
      phase_d   = '0;
      hold_d    = '0;
    end else begin
      unique case (state_q)
        StIdleOff: begin
          ready_d   = 1'b1;
          holding_d = 1'b0;
          phase_d   = '0;
          hold_d    = '0;
          if (accept) begin
            if (is_release) begin
              // Redundant off pulse keeps the hold register in a known state.
              off_d  = 1'b1;
              done_d = 1'b1;
            end else if (is_grab) begin
              on_d      = 1'b1;
              state_d   = StSettleOn;
              ready_d   = 1'b0;
              holding_d = 1'b1;
            end
          end
        end

        StSettleOn: begin
          hold_d = hold_q + 1'b1;
          if (phase_q == SettleLast) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = StHolding;
            phase_d = '0;
          end
        end

        StHolding: begin
          hold_d  = hold_q + 1'b1;
          phase_d = '0;
          if (accept) begin
            if (is_release) begin
              off_d     = 1'b1;
              state_d   = StSettleOff;
              ready_d   = 1'b0;
              holding_d = 1'b0;
              hold_d    = '0;
            end else if (is_grab) begin
              done_d = 1'b1;
            end
          end
        end

        StSettleOff: begin
          hold_d = '0;
          if (phase_q == SettleLast) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = StIdleOff;
            phase_d = '0;
          end
        end

        StCooldown: begin
          hold_d = '0;
          if (phase_q == CoolLast) begin
            ready_d = 1'b1;
            state_d = StIdleOff;
            phase_d = '0;
          end
        end

        default: begin
          state_d   = StIdleOff;
          off_d     = 1'b1;
          ready_d   = 1'b0;
          holding_d = 1'b0;
          phase_d   = '0;
          hold_d    = '0;
        end
      endcase
    end
  end

  assign bus.magnet_on  = on_q;
  assign bus.magnet_off = off_q;
  assign bus.done       = done_q;
  assign bus.cmd_ready  = ready_q;
  assign bus.holding    = holding_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_magnet_sequencer.sv
// Bench for magnet_sequencer with short timings (settle 4, max hold 20,
// cooldown 8). A deadline-based reference model predicts every output for
// every cycle; directed scenarios are followed by a random stretch.
module tb_magnet_sequencer;

  localparam int S    = 4;
  localparam int MAXH = 20;
  localparam int COOL = 8;

  logic clk = 1'b0;
  logic rst_n;
  magnet_sequencer_if bus ();

  magnet_sequencer #(
    .CNT_W          (16),
    .SETTLE_CYCLES  (S),
    .MAX_HOLD_CYCLES(MAXH),
    .COOLDOWN_CYCLES(COOL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;  // index of the cycle that follows the latest posedge

  // Reference model: magnet state plus absolute deadlines in cycle numbers.
  bit m_on;          // magnet commanded on
  bit m_busy;        // settling or cooling down, commands refused
  int m_busy_until;  // cycle in which ready comes back
  bit m_done_pend;   // whether done fires when busy ends
  int m_wd_at;       // cycle of forced release while on
  logic exp_on, exp_off, exp_done, exp_ready, exp_holding, exp_fault;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle %0d: observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rn, input bit v, input bit g, input bit r,
                            input bit e, input bit fc);
    bit accept;
    accept   = v && (exp_ready === 1'b1);
    exp_on   = 1'b0;
    exp_off  = 1'b0;
    exp_done = 1'b0;
    if (!rn) begin
      m_on = 0; m_busy = 0; m_done_pend = 0;
      exp_off = 1'b1; exp_fault = 1'b0; exp_ready = 1'b0; exp_holding = 1'b0;
      return;
    end
    exp_fault = exp_fault && !fc;
    if (e) begin
      exp_off = 1'b1;
      m_on = 0; m_busy = 0; m_done_pend = 0;
    end else if (m_on && n == m_wd_at) begin
      exp_off = 1'b1; exp_fault = 1'b1;
      m_on = 0; m_busy = 1; m_busy_until = n + COOL; m_done_pend = 0;
    end else if (m_busy && n == m_busy_until) begin
      m_busy = 0;
      exp_done = m_done_pend;
    end else if (!m_busy && accept) begin
      if (r) begin
        exp_off = 1'b1;
        if (m_on) begin
          m_on = 0; m_busy = 1; m_busy_until = n + S; m_done_pend = 1;
        end else begin
          exp_done = 1'b1;
        end
      end else if (g) begin
        if (m_on) begin
          exp_done = 1'b1;
        end else begin
          exp_on = 1'b1;
          m_on = 1; m_busy = 1; m_busy_until = n + S; m_done_pend = 1;
          m_wd_at = n + MAXH;
        end
      end
    end
    exp_ready   = !e && !m_busy;
    exp_holding = m_on;
  endtask

  // One clock: drive inputs, model the edge, compare all outputs on the negedge.
  task automatic step(input bit rn, input bit v, input bit g, input bit r,
                      input bit e, input bit fc);
    rst_n         = rn;
    bus.cmd_valid = v;
    bus.cmd_grab  = g;
    bus.cmd_release = r;
    bus.estop     = e;
    bus.fault_clr = fc;
    @(posedge clk);
    n++;
    model_edge(rn, v, g, r, e, fc);
    @(negedge clk);
    check("magnet_on",  bus.magnet_on,  exp_on);
    check("magnet_off", bus.magnet_off, exp_off);
    check("done",       bus.done,       exp_done);
    check("cmd_ready",  bus.cmd_ready,  exp_ready);
    check("holding",    bus.holding,    exp_holding);
    check("fault",      bus.fault,      exp_fault);
    check("on_off_excl", bus.magnet_on & bus.magnet_off, 1'b0);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    exp_ready = 1'b0;
    exp_fault = 1'b0;

    // Reset for 3 cycles, then release.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    idle(1);

    // Grab, settle, release, settle.
    step(1, 1, 1, 0, 0, 0);
    idle(5);
    step(1, 1, 0, 1, 0, 0);
    idle(5);

    // Grab and release together while holding: release wins.
    step(1, 1, 1, 0, 0, 0);
    idle(5);
    step(1, 1, 1, 1, 0, 0);
    idle(5);

    // Grab and hold past the watchdog; fault stays until fault_clr.
    step(1, 1, 1, 0, 0, 0);
    idle(MAXH + COOL + 3);
    step(1, 0, 0, 0, 0, 1);
    idle(2);

    // Grab while already holding gives done with no pulse.
    step(1, 1, 1, 0, 0, 0);
    idle(5);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    idle(5);

    // estop during settle-on aborts; a later grab works normally.
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    idle(6);
    step(1, 1, 1, 0, 0, 0);
    idle(5);
    step(1, 1, 0, 1, 0, 0);
    idle(5);

    // Release while idle: redundant off and immediate done.
    step(1, 1, 0, 1, 0, 0);
    idle(2);

    // Valid with neither bit set is swallowed.
    step(1, 1, 0, 0, 0, 0);
    idle(1);

    // Random stretch, with an occasional reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 19) == 0));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
